lcd_write_scheduler: RTL and testbench

// - Shares the LCD character controller between two character producers (A, B). Grants them

---
 rtl/lcd_pkg.sv | 21 ++
 rtl/lcd_char_fifo.sv | 57 +++++
 rtl/lcd_write_scheduler.sv | 169 ++++++++++++++++
 tb/tb_lcd_write_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write scheduler: FSM encoding, default timing and character width.
package lcd_pkg;

    localparam int LCD_CHAR_W    = 8;
    localparam int LCD_INIT_WAIT = 900000;
    localparam int LCD_CHAR_WAIT = 4000;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_INIT_PULSE = 3'd1,
        S_INIT_WAIT  = 3'd2,
        S_READY      = 3'd3,
        S_SEND       = 3'd4,
        S_HOLD       = 3'd5
    } lcd_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_char_fifo.sv
// Synchronous first-word-fall-through character FIFO; dout shows the head entry whenever
// empty is low. Pushes while full and pops while empty are ignored.
module lcd_char_fifo
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int WIDTH      = LCD_CHAR_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [WIDTH-1:0]            din,
    input  logic                        pop,
    output logic [WIDTH-1:0]            dout,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        count    = wr_ptr_q - rd_ptr_q;
        dout     = mem_q[rd_ptr_q[AW-1:0]];
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/lcd_write_scheduler.sv
// Shares the LCD character controller between producers A and B: round-robin grant,
// character FIFO, and timer-paced init/enviar pulses (the controller has no done flag).
//
//   state        | meaning
//   S_IDLE       | waiting for auto-start or start
//   S_INIT_PULSE | init high for one cycle, load init timer
//   S_INIT_WAIT  | down-count until controller initialisation is over
//   S_READY      | idle and ready; leave as soon as the FIFO holds a character
//   S_SEND       | enviar high, FIFO head popped, load hold timer
//   S_HOLD       | down-count so enviar pulses are CHAR_WAIT cycles apart
module lcd_write_scheduler
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int INIT_WAIT  = LCD_INIT_WAIT,
    parameter int CHAR_WAIT  = LCD_CHAR_WAIT,
    parameter bit AUTO_START = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        req_a,
    input  logic [LCD_CHAR_W-1:0]       data_a,
    output logic                        ack_a,
    input  logic                        req_b,
    input  logic [LCD_CHAR_W-1:0]       data_b,
    output logic                        ack_b,
    output logic                        init,
    output logic                        enviar,
    output logic [LCD_CHAR_W-1:0]       info,
    output logic                        ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [15:0]                 sent_count
);

    localparam int TMR_W = $clog2(max_int(INIT_WAIT, CHAR_WAIT) + 1);

    // INIT_WAIT spans the init pulse plus the wait state, so the wait state lasts
    // INIT_WAIT-1 cycles. SEND plus HOLD plus one READY cycle gives CHAR_WAIT spacing.
    localparam logic [TMR_W-1:0] INIT_LOAD = TMR_W'(max_int(INIT_WAIT - 2, 0));
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(max_int(CHAR_WAIT - 3, 0));
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

    lcd_state_e                state_q, state_d;
    logic [TMR_W-1:0]          timer_q, timer_d;
    logic                      init_q, init_d;
    logic                      enviar_q, enviar_d;
    logic                      ready_q, ready_d;
    logic [LCD_CHAR_W-1:0]     info_q, info_d;
    logic [15:0]               sent_q, sent_d;
    logic                      prio_b_q, prio_b_d;

    logic                      grant_a, grant_b;
    logic                      fifo_push, fifo_pop;
    logic                      fifo_full, fifo_empty;
    logic [LCD_CHAR_W-1:0]     fifo_din, fifo_dout;

    lcd_char_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (LCD_CHAR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // prio_b_q set means A won the last grant, so B wins the next tie.
    always_comb begin
        grant_a   = req_a && (!req_b || !prio_b_q);
        grant_b   = req_b && (!req_a ||  prio_b_q);
        ack_a     = grant_a && !fifo_full;
        ack_b     = grant_b && !fifo_full;
        fifo_push = ack_a || ack_b;
        fifo_din  = ack_b ? data_b : data_a;
        prio_b_d  = prio_b_q;
        if (ack_a) begin
            prio_b_d = 1'b1;
        end else if (ack_b) begin
            prio_b_d = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        info_d   = info_q;
        sent_d   = sent_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (AUTO_START || start) begin
                    state_d = S_INIT_PULSE;
                end
            end
            S_INIT_PULSE: begin
                timer_d = INIT_LOAD;
                state_d = S_INIT_WAIT;
            end
            S_INIT_WAIT: begin
                if (timer_q == '0) begin
                    state_d = S_READY;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            S_READY: begin
                // Latch the head now so info is already valid while enviar is high.
                if (!fifo_empty) begin
                    info_d  = fifo_dout;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                fifo_pop = 1'b1;
                sent_d   = sent_q + 16'd1;
                timer_d  = HOLD_LOAD;
                state_d  = S_HOLD;
            end
            S_HOLD: begin
                if (timer_q == '0) begin
                    state_d = S_READY;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        init_d   = (state_d == S_INIT_PULSE);
        enviar_d = (state_d == S_SEND);
        ready_d  = ready_q || (state_d == S_READY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            init_q   <= 1'b0;
            enviar_q <= 1'b0;
            ready_q  <= 1'b0;
            info_q   <= '0;
            sent_q   <= '0;
            prio_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            init_q   <= init_d;
            enviar_q <= enviar_d;
            ready_q  <= ready_d;
            info_q   <= info_d;
            sent_q   <= sent_d;
            prio_b_q <= prio_b_d;
        end
    end

    assign init       = init_q;
    assign enviar     = enviar_q;
    assign ready      = ready_q;
    assign info       = info_q;
    assign sent_count = sent_q;

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Bench for lcd_write_scheduler with small timing: table vectors, directed corner
// sequences and randomized producers, all checked against a cycle-stamped reference model.
module tb_lcd_write_scheduler;

    localparam int DEPTH = 4;
    localparam int IW    = 20;
    localparam int CW    = 5;

    logic       clk;
    logic       reset;
    logic       start;
    logic       req_a, req_b;
    logic [7:0] data_a, data_b;
    logic       ack_a, ack_b;
    logic       init, enviar, ready;
    logic [7:0] info;
    logic [2:0] fifo_count;
    logic [15:0] sent_count;

    lcd_write_scheduler #(
        .FIFO_DEPTH (DEPTH),
        .INIT_WAIT  (IW),
        .CHAR_WAIT  (CW),
        .AUTO_START (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .req_a      (req_a),
        .data_a     (data_a),
        .ack_a      (ack_a),
        .req_b      (req_b),
        .data_b     (data_b),
        .ack_b      (ack_b),
        .init       (init),
        .enviar     (enviar),
        .info       (info),
        .ready      (ready),
        .fifo_count (fifo_count),
        .sent_count (sent_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: m_k counts cycles since the last reset edge. Init pulses at k=1,
    // ready from k=IW+1, and a send needs a ready cycle with data and CW cycles since the last.
    int         m_k;
    logic [7:0] m_q[$];
    int         m_sent;
    int         m_last;
    bit         m_prio_b;
    logic [7:0] m_info;
    bit         m_send;
    bit         m_ack_a = 1'b0;
    bit         m_ack_b = 1'b0;

    int   obs_k;
    logic obs_init, obs_enviar, obs_ready, obs_ack_a, obs_ack_b;
    logic [7:0]  obs_info;
    logic [2:0]  obs_count;
    logic [15:0] obs_sent;

    int env_info[$];
    int env_k[$];
    int ack_seq[$];
    int ack_k[$];
    int first_init_k;
    int first_ready_k;

    logic [7:0] pa[$];
    logic [7:0] pb[$];

    typedef struct {
        bit         ra;
        bit         rb;
        logic [7:0] da;
        logic [7:0] db;
        bit         e_ack_a;
        bit         e_ack_b;
        int         e_count;
        bit         e_init;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic model_clear();
        m_k      = 0;
        m_q.delete();
        m_sent   = 0;
        m_last   = -1000;
        m_prio_b = 1'b0;
        m_info   = 8'h00;
        m_send   = 1'b0;
    endtask

    task automatic clear_logs();
        env_info.delete();
        env_k.delete();
        ack_seq.delete();
        ack_k.delete();
        first_init_k  = -1;
        first_ready_k = -1;
    endtask

    // Called at a negedge with this cycle's inputs applied; returns at the next negedge.
    task automatic tick();
        logic [7:0] e_info;
        bit full, ga, gb, ea, eb, nxt;
        #1;
        obs_k      = m_k;
        obs_init   = init;
        obs_enviar = enviar;
        obs_ready  = ready;
        obs_info   = info;
        obs_count  = fifo_count;
        obs_sent   = sent_count;
        obs_ack_a  = ack_a;
        obs_ack_b  = ack_b;
        full   = (m_q.size() >= DEPTH);
        ga     = req_a && (!req_b || !m_prio_b);
        gb     = req_b && (!req_a ||  m_prio_b);
        ea     = ga && !full;
        eb     = gb && !full;
        e_info = m_send ? m_q[0] : m_info;
        chk("init",       32'(init),       32'(m_k == 1));
        chk("ready",      32'(ready),      32'(m_k >= IW + 1));
        chk("enviar",     32'(enviar),     32'(m_send));
        chk("info",       32'(info),       32'(e_info));
        chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        chk("sent_count", 32'(sent_count), 32'(m_sent));
        chk("ack_a",      32'(ack_a),      32'(ea));
        chk("ack_b",      32'(ack_b),      32'(eb));
        if (enviar === 1'b1) begin
            env_info.push_back(int'(info));
            env_k.push_back(m_k);
        end
        if (ack_a === 1'b1) begin ack_seq.push_back(0); ack_k.push_back(m_k); end
        if (ack_b === 1'b1) begin ack_seq.push_back(1); ack_k.push_back(m_k); end
        if (init === 1'b1 && first_init_k < 0) first_init_k = m_k;
        if (ready === 1'b1 && first_ready_k < 0) first_ready_k = m_k;
        m_ack_a = ea;
        m_ack_b = eb;
        if (reset) begin
            model_clear();
        end else begin
            nxt = !m_send && (m_k >= IW + 1) && (m_q.size() > 0) && (m_k + 1 - m_last >= CW);
            if (m_send) begin
                m_info = m_q.pop_front();
                m_sent = (m_sent + 1) % 65536;
                m_last = m_k;
            end
            if (ea) begin
                m_q.push_back(data_a);
                m_prio_b = 1'b1;
            end else if (eb) begin
                m_q.push_back(data_b);
                m_prio_b = 1'b0;
            end
            m_k++;
            m_send = nxt;
        end
        @(negedge clk);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
        reset = 1'b0;
        clear_logs();
    endtask

    // Producers walk pa/pb, holding each character until it is acknowledged.
    task automatic run_producers(input int ncyc);
        int ia;
        int ib;
        ia = 0;
        ib = 0;
        for (int c = 0; c < ncyc; c++) begin
            req_a  = (ia < pa.size());
            data_a = req_a ? pa[ia] : 8'h00;
            req_b  = (ib < pb.size());
            data_b = req_b ? pb[ib] : 8'h00;
            tick();
            if (m_ack_a) ia++;
            if (m_ack_b) ib++;
        end
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    initial begin
        int dens;
        tbl[0] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 8'h11, 8'h20, 1'b0, 1'b1, 1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 8'h11, 8'h21, 1'b1, 1'b0, 2, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 8'h00, 8'h21, 1'b0, 1'b1, 3, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 8'h12, 8'h22, 1'b0, 1'b0, 4, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4, 1'b0};

        reset  = 1'b1;
        start  = 1'b0;
        req_a  = 1'b0;
        req_b  = 1'b0;
        data_a = 8'h00;
        data_b = 8'h00;
        repeat (3) @(negedge clk);
        model_clear();
        clear_logs();
        reset = 1'b0;

        // Idle after reset: init at k=1, ready 20 cycles later, no enviar.
        pa.delete();
        pb.delete();
        run_producers(30);
        chk("init_cycle",   32'(first_init_k), 32'(1));
        chk("ready_delay",  32'(first_ready_k - first_init_k), 32'(IW));
        chk("idle_enviar",  32'(env_info.size()), 32'(0));

        // Table vectors from reset: arbitration, fill to full, then in-order drain.
        reset_dut();
        for (int i = 0; i < 7; i++) begin
            req_a  = tbl[i].ra;
            data_a = tbl[i].da;
            req_b  = tbl[i].rb;
            data_b = tbl[i].db;
            tick();
            chk($sformatf("tbl%0d_ack_a", i), 32'(obs_ack_a), 32'(tbl[i].e_ack_a));
            chk($sformatf("tbl%0d_ack_b", i), 32'(obs_ack_b), 32'(tbl[i].e_ack_b));
            chk($sformatf("tbl%0d_count", i), 32'(obs_count), 32'(tbl[i].e_count));
            chk($sformatf("tbl%0d_init",  i), 32'(obs_init),  32'(tbl[i].e_init));
        end
        pa.delete();
        pb.delete();
        run_producers(38);
        chk("tbl_drain_0", 32'(qget(env_info, 0)), 32'h10);
        chk("tbl_drain_1", 32'(qget(env_info, 1)), 32'h20);
        chk("tbl_drain_2", 32'(qget(env_info, 2)), 32'h11);
        chk("tbl_drain_3", 32'(qget(env_info, 3)), 32'h21);
        chk("tbl_first_send_k", 32'(qget(env_k, 0)), 32'(IW + 2));
        chk("tbl_spacing", 32'(qget(env_k, 3) - qget(env_k, 0)), 32'(3 * CW));

        // 'H' then 'I' after ready.
        reset_dut();
        run_producers(25);
        pa.push_back(8'h48);
        pa.push_back(8'h49);
        run_producers(20);
        chk("hi_sends",   32'(env_info.size()), 32'(2));
        chk("hi_first",   32'(qget(env_info, 0)), 32'h48);
        chk("hi_second",  32'(qget(env_info, 1)), 32'h49);
        chk("hi_spacing", 32'(qget(env_k, 1) - qget(env_k, 0)), 32'(CW));
        chk("hi_sent",    32'(obs_sent), 32'(2));
        chk("hi_info",    32'(obs_info), 32'h49);

        // Both requesting continuously: A,B,A,B.
        reset_dut();
        pa.delete();
        pb.delete();
        pa.push_back(8'h41);
        pa.push_back(8'h41);
        pb.push_back(8'h42);
        pb.push_back(8'h42);
        run_producers(45);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_ack%0d", i), 32'(qget(ack_seq, i)), 32'(i % 2));
            chk($sformatf("rr_env%0d", i), 32'(qget(env_info, i)), (i % 2 == 0) ? 32'h41 : 32'h42);
        end

        // Flood before ready: four acks, fifth waits for the first pop.
        reset_dut();
        pa.delete();
        pb.delete();
        for (int i = 0; i < 5; i++) pa.push_back(8'(8'h61 + i));
        run_producers(50);
        chk("fl_ack_k0", 32'(qget(ack_k, 0)), 32'(0));
        chk("fl_ack_k3", 32'(qget(ack_k, 3)), 32'(3));
        chk("fl_ack_k4", 32'(qget(ack_k, 4)), 32'(qget(env_k, 0) + 1));
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fl_env%0d", i), 32'(qget(env_info, i)), 32'(8'h61 + i));
        end
        chk("fl_spacing", 32'(qget(env_k, 4) - qget(env_k, 0)), 32'(4 * CW));

        // Push and pop in the same cycle.
        reset_dut();
        pa.delete();
        pb.delete();
        pb.push_back(8'h71);
        pb.push_back(8'h72);
        pb.push_back(8'h73);
        run_producers(IW + 2);
        req_b  = 1'b1;
        data_b = 8'h74;
        tick();
        req_b = 1'b0;
        chk("pp_enviar", 32'(obs_enviar), 32'(1));
        chk("pp_ack_b",  32'(obs_ack_b),  32'(1));
        chk("pp_count0", 32'(obs_count),  32'(3));
        tick();
        chk("pp_count1", 32'(obs_count),  32'(3));
        pb.delete();
        run_producers(20);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pp_env%0d", i), 32'(qget(env_info, i)), 32'(8'h71 + i));
        end

        // Reset during HOLD with three entries queued.
        reset_dut();
        pb.delete();
        for (int i = 0; i < 4; i++) pb.push_back(8'(8'h81 + i));
        run_producers(IW + 4);
        reset_dut();
        chk("rh_count_pre", 32'(obs_count), 32'(3));
        chk("rh_info_pre",  32'(obs_info),  32'h81);
        tick();
        chk("rh_count", 32'(obs_count), 32'(0));
        chk("rh_ready", 32'(obs_ready), 32'(0));
        chk("rh_info",  32'(obs_info),  32'(0));
        chk("rh_sent",  32'(obs_sent),  32'(0));
        pb.delete();
        run_producers(3);
        chk("rh_reinit", 32'(first_init_k), 32'(1));

        // Randomized producers, start toggling and occasional resets.
        reset_dut();
        for (int c = 0; c < 4000; c++) begin
            case (c / 1000)
                0:       dens = 10;
                1:       dens = 40;
                2:       dens = 90;
                default: dens = 60;
            endcase
            if (!req_a || m_ack_a) begin
                req_a  = ($urandom_range(0, 99) < dens);
                data_a = 8'($urandom);
            end
            if (!req_b || m_ack_b) begin
                req_b  = ($urandom_range(0, 99) < dens);
                data_b = 8'($urandom);
            end
            start = 1'($urandom);
            reset = ($urandom_range(0, 599) == 0);
            tick();
        end
        reset = 1'b0;
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
